// File: rtl/aes128_iter_engine.sv
// aes128_iter_engine: iterative AES-128 encryptor, UNROLL rounds per clock, ECB/CBC.
// Define AES_KEYOUT_EN to expose the final round key on keyout.
module aes128_iter_engine #(
  parameter int UNROLL        = 1,
  parameter bit MODE_CBC_ONLY = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  input  logic         in_first,
  input  logic         mode,
  input  logic [127:0] iv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
`ifdef AES_KEYOUT_EN
  output logic [127:0] keyout,
`endif
  output logic         busy
);

  if (!(UNROLL == 1 || UNROLL == 2 ||
        UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
    $fatal(1, "aes128_iter_engine: illegal UNROLL %0d", UNROLL);
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Table is stored byte 0 at the MSB, hence the inverted index.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [127:0] key_next(
    input logic [127:0] k,
    input logic [7:0]   rc
  );
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]),
          sbox(w3[7:0]), sbox(w3[31:24])};
    t  = t ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] aes_round(
    input logic [127:0] s,
    input logic [127:0] k,
    input logic         last
  );
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   m [16];
    logic [127:0] r;
    for (int i = 0; i < 16; i++)
      a[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        b[4*c+w] = a[4*((c+w)%4)+w];
    for (int c = 0; c < 4; c++) begin
      if (last) begin
        for (int w = 0; w < 4; w++)
          m[4*c+w] = b[4*c+w];
      end else begin
        m[4*c]   = xt(b[4*c]) ^ xt(b[4*c+1]) ^ b[4*c+1]
                 ^ b[4*c+2] ^ b[4*c+3];
        m[4*c+1] = b[4*c] ^ xt(b[4*c+1]) ^ xt(b[4*c+2])
                 ^ b[4*c+2] ^ b[4*c+3];
        m[4*c+2] = b[4*c] ^ b[4*c+1] ^ xt(b[4*c+2])
                 ^ xt(b[4*c+3]) ^ b[4*c+3];
        m[4*c+3] = xt(b[4*c]) ^ b[4*c] ^ b[4*c+1]
                 ^ b[4*c+2] ^ xt(b[4*c+3]);
      end
    end
    r = '0;
    for (int i = 0; i < 16; i++)
      r[127-8*i -: 8] = m[i];
    return r ^ k;
  endfunction

  state_e       fsm_q, fsm_d;
  logic [127:0] st_q, st_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] chain_q, chain_d;
  logic         cbc_q, cbc_d;
  logic [127:0] out_q, out_d;
`ifdef AES_KEYOUT_EN
  logic [127:0] kout_q, kout_d;
`endif

  logic [127:0] rs, rk;
  logic [3:0]   rnd_nx;
  logic         use_cbc;
  logic [127:0] pre;

  // UNROLL chained copies of the round + key-schedule datapath.
  always_comb begin : p_rounds
    logic [3:0] idx;
    idx = '0;
    rs  = st_q;
    rk  = rk_q;
    for (int j = 0; j < UNROLL; j++) begin
      idx = rnd_q + 4'(j) + 4'd1;
      rk  = key_next(rk, rcon(idx));
      rs  = aes_round(rs, rk, idx == 4'd10);
    end
  end

  assign rnd_nx  = rnd_q + 4'(UNROLL);
  assign use_cbc = MODE_CBC_ONLY ? 1'b1 : mode;
  assign pre     = in_data ^ (use_cbc ?
                   (in_first ? iv : chain_q) : 128'h0);

  always_comb begin
    fsm_d   = fsm_q;
    st_d    = st_q;
    rk_d    = rk_q;
    rnd_d   = rnd_q;
    chain_d = chain_q;
    cbc_d   = cbc_q;
    out_d   = out_q;
`ifdef AES_KEYOUT_EN
    kout_d  = kout_q;
`endif
    case (fsm_q)
      S_IDLE: begin
        if (in_valid) begin
          st_d  = pre ^ in_key;
          rk_d  = in_key;
          rnd_d = '0;
          cbc_d = use_cbc;
          fsm_d = S_RUN;
        end
      end
      S_RUN: begin
        st_d  = rs;
        rk_d  = rk;
        rnd_d = rnd_nx;
        if (rnd_nx == 4'd10) begin
          out_d = rs;
`ifdef AES_KEYOUT_EN
          kout_d = rk;
`endif
          fsm_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          if (cbc_q)
            chain_d = out_q;
          fsm_d = S_IDLE;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= S_IDLE;
      st_q    <= '0;
      rk_q    <= '0;
      rnd_q   <= '0;
      chain_q <= '0;
      cbc_q   <= 1'b0;
      out_q   <= '0;
`ifdef AES_KEYOUT_EN
      kout_q  <= '0;
`endif
    end else begin
      fsm_q   <= fsm_d;
      st_q    <= st_d;
      rk_q    <= rk_d;
      rnd_q   <= rnd_d;
      chain_q <= chain_d;
      cbc_q   <= cbc_d;
      out_q   <= out_d;
`ifdef AES_KEYOUT_EN
      kout_q  <= kout_d;
`endif
    end
  end

  assign in_ready  = (fsm_q == S_IDLE) && !rst;
  assign out_valid = (fsm_q == S_DONE);
  assign out_data  = out_q;
  assign busy      = (fsm_q != S_IDLE);
`ifdef AES_KEYOUT_EN
  assign keyout    = kout_q;
`endif

endmodule

// File: tb/tb_aes128_iter_engine.sv
// tb_aes128_iter_engine: known-answer table, reset/back-pressure sequences and
// random ECB/CBC traffic against a byte-level AES model, on UNROLL 1, 2 and 10.
module tb_aes128_iter_engine;

  localparam int NI = 3;
  localparam int UL [NI] = '{1, 2, 10};

  logic         clk;
  logic         rst       [NI];
  logic         in_valid  [NI];
  logic         in_ready  [NI];
  logic [127:0] in_data   [NI];
  logic [127:0] in_key    [NI];
  logic         in_first  [NI];
  logic         mode      [NI];
  logic [127:0] iv        [NI];
  logic         out_valid [NI];
  logic         out_ready [NI];
  logic [127:0] out_data  [NI];
  logic         busy      [NI];
`ifdef AES_KEYOUT_EN
  logic [127:0] keyout    [NI];
`endif

  for (genvar g = 0; g < NI; g++) begin : g_dut
    aes128_iter_engine #(.UNROLL(UL[g]), .MODE_CBC_ONLY(1'b0)) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .in_key    (in_key[g]),
      .in_first  (in_first[g]),
      .mode      (mode[g]),
      .iv        (iv[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
`ifdef AES_KEYOUT_EN
      .keyout    (keyout[g]),
`endif
      .busy      (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0]   sb [256];
  logic [127:0] chain_m [NI];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, x;
    for (int v = 0; v < 256; v++) begin
      x   = 8'(v);
      inv = 8'h00;
      if (v != 0) begin
        inv = 8'h01;
        for (int e = 0; e < 254; e++) inv = gmul(inv, x);
      end
      sb[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
            ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic aes_ref(input logic [127:0] key, input logic [127:0] blk,
                         output logic [127:0] ct, output logic [127:0] rk10);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  st [16];
    logic [7:0]  tmp [16];
    logic [7:0]  rc;
    logic [7:0]  cf [4];
    cf = '{8'h02, 8'h03, 8'h01, 8'h01};
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t  = t ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++)
      st[i] = blk[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) st[i] = sb[st[i]];
      for (int i = 0; i < 16; i++) tmp[i] = st[(i + 4*(i%4)) % 16];
      for (int i = 0; i < 16; i++) st[i] = tmp[i];
      if (r < 10) begin
        for (int i = 0; i < 16; i++) begin
          tmp[i] = 8'h00;
          for (int j = 0; j < 4; j++)
            tmp[i] = tmp[i] ^ gmul(cf[(j - i%4 + 4) % 4], st[4*(i/4)+j]);
        end
        for (int i = 0; i < 16; i++) st[i] = tmp[i];
      end
      for (int i = 0; i < 16; i++)
        st[i] = st[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = st[i];
    rk10 = {w[40], w[41], w[42], w[43]};
  endtask

  // ---------------- one block through instance k ----------------
  task automatic xfer(input int k, input logic [127:0] key,
                      input logic [127:0] pt, input logic [127:0] ivv,
                      input logic first, input logic md,
                      input logic [127:0] ect, input int hold,
                      input bit early, input string nm);
    int lat;
    bit seen;
`ifdef AES_KEYOUT_EN
    logic [127:0] d0, erk;
    aes_ref(key, 128'h0, d0, erk);
`endif
    @(negedge clk);
    chk({nm, "_in_ready_idle"}, 128'(in_ready[k]), 128'd1);
    in_valid[k] = 1'b1; in_data[k] = pt; in_key[k] = key;
    in_first[k] = first; mode[k] = md; iv[k] = ivv;
    out_ready[k] = 1'b0;
    @(posedge clk); #1;
    chk({nm, "_busy_run"}, 128'(busy[k]), 128'd1);
    chk({nm, "_in_ready_run"}, 128'(in_ready[k]), 128'd0);
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      in_valid[k] = 1'($urandom);
      in_data[k]  = {$urandom, $urandom, $urandom, $urandom};
      mode[k]     = 1'($urandom);
      in_first[k] = 1'($urandom);
      iv[k]       = {$urandom, $urandom, $urandom, $urandom};
      out_ready[k] = early;
      @(posedge clk); #1;
      lat++;
      if (out_valid[k]) seen = 1'b1;
    end
    in_valid[k]  = 1'b0;
    out_ready[k] = (hold == 0);
    chk({nm, "_latency"}, 128'(lat), 128'(10 / UL[k]));
    chk({nm, "_out_data"}, out_data[k], ect);
`ifdef AES_KEYOUT_EN
    chk({nm, "_keyout"}, keyout[k], erk);
`endif
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({nm, "_hold_valid"}, 128'(out_valid[k]), 128'd1);
      chk({nm, "_hold_data"}, out_data[k], ect);
      chk({nm, "_hold_in_ready"}, 128'(in_ready[k]), 128'd0);
    end
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
    chk({nm, "_drained_valid"}, 128'(out_valid[k]), 128'd0);
    chk({nm, "_idle_in_ready"}, 128'(in_ready[k]), 128'd1);
    chk({nm, "_idle_busy"}, 128'(busy[k]), 128'd0);
    if (md) chain_m[k] = ect;
  endtask

  typedef struct {
    int           k;
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] iv;
    logic         first;
    logic         md;
    logic [127:0] ct;
    int           hold;
  } vec_t;

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV1 = 128'h000102030405060708090a0b0c0d0e0f;

  initial begin
    vec_t tv [7];
    logic [127:0] key, pt, ivv, pre, ect, erk;
    logic first, md;
    int k, hold;
    bit seen_ov;

    tv[0] = '{0, K1, 128'h3243f6a8885a308d313198a2e0370734, 128'h0,
              1'b0, 1'b0, 128'h3925841d02dc09fbdc118597196a0b32, 7};
    tv[1] = '{2, 128'h5468617473206D79204B756E67204675,
              128'h54776F204F6E65204E696E652054776F, 128'h0,
              1'b0, 1'b0, 128'h29c3505f571420f6402299b31a02d73a, 0};
    tv[2] = '{2, IV1, 128'h00112233445566778899aabbccddeeff, 128'h0,
              1'b0, 1'b0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 2};
    tv[3] = '{1, K1, 128'h6bc1bee22e409f96e93d7e117393172a, IV1,
              1'b1, 1'b1, 128'h7649abac8119b246cee98e9b12e9197d, 0};
    tv[4] = '{1, K1, 128'hae2d8a571e03ac9c9eb76fac45af8e51, 128'h0,
              1'b0, 1'b1, 128'h5086cb9b507219ee95db113a917678b2, 1};
    tv[5] = '{1, K1, 128'h3243f6a8885a308d313198a2e0370734,
              128'hdeadbeef0123456789abcdef55aa55aa,
              1'b1, 1'b0, 128'h3925841d02dc09fbdc118597196a0b32, 0};
    tv[6] = '{1, K1, 128'h30c81c46a35ce411e5fbc1191a0a52ef, IV1,
              1'b0, 1'b1, 128'h73bed6b8e3c1743b7116e69e22229516, 0};

    build_sbox();
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1; in_valid[i] = 1'b0; in_data[i] = '0;
      in_key[i] = '0; in_first[i] = 1'b0; mode[i] = 1'b0;
      iv[i] = '0; out_ready[i] = 1'b0; chain_m[i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst%0d_in_ready", i), 128'(in_ready[i]), 128'd0);
      chk($sformatf("rst%0d_out_valid", i), 128'(out_valid[i]), 128'd0);
      chk($sformatf("rst%0d_out_data", i), out_data[i], 128'd0);
      chk($sformatf("rst%0d_busy", i), 128'(busy[i]), 128'd0);
`ifdef AES_KEYOUT_EN
      chk($sformatf("rst%0d_keyout", i), keyout[i], 128'd0);
`endif
      rst[i] = 1'b0;
    end
    #1;
    for (int i = 0; i < NI; i++)
      chk($sformatf("rel%0d_in_ready", i), 128'(in_ready[i]), 128'd1);

    for (int i = 0; i < 7; i++)
      xfer(tv[i].k, tv[i].key, tv[i].pt, tv[i].iv, tv[i].first,
           tv[i].md, tv[i].ct, tv[i].hold, 1'b0, $sformatf("tv%0d", i));

    // Abort a block on UNROLL=1 with a reset at the 4th edge after accept.
    @(negedge clk);
    in_valid[0] = 1'b1; in_data[0] = tv[0].pt; in_key[0] = K1;
    mode[0] = 1'b1; in_first[0] = 1'b1; iv[0] = IV1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b1;
    #1;
    chk("midrst_in_ready_low", 128'(in_ready[0]), 128'd0);
    @(negedge clk);
    rst[0] = 1'b0;
    chain_m[0] = '0;
    #1;
    chk("midrst_busy", 128'(busy[0]), 128'd0);
    chk("midrst_in_ready", 128'(in_ready[0]), 128'd1);
    seen_ov = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (out_valid[0]) seen_ov = 1'b1;
    end
    chk("midrst_no_output", 128'(seen_ov), 128'd0);
    xfer(0, K1, tv[0].pt, 128'h0, 1'b0, 1'b0, tv[0].ct, 0, 1'b0, "post_rst");
    // CBC with in_first=0 right after reset uses a zero chain.
    aes_ref(K1, tv[3].pt, ect, erk);
    xfer(0, K1, tv[3].pt, IV1, 1'b0, 1'b1, ect, 0, 1'b0, "post_rst_cbc");

    for (int n = 0; n < 30; n++) begin
      k     = int'($urandom_range(0, NI - 1));
      key   = {$urandom, $urandom, $urandom, $urandom};
      pt    = {$urandom, $urandom, $urandom, $urandom};
      ivv   = {$urandom, $urandom, $urandom, $urandom};
      first = 1'($urandom);
      md    = 1'($urandom);
      hold  = int'($urandom_range(0, 3));
      pre   = pt ^ (md ? (first ? ivv : chain_m[k]) : 128'h0);
      aes_ref(key, pre, ect, erk);
      xfer(k, key, pt, ivv, first, md, ect, hold, 1'($urandom),
           $sformatf("rnd%0d_u%0d", n, UL[k]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
